// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pin in, cleaned level and pulses out.
// master = pin driver / pulse consumer, slave = conditioner.
interface btn_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic tap_pulse;
  logic long_pulse;
  logic held_long;

  modport master (
    output btn_in,
    input  btn_level,
    input  tap_pulse,
    input  long_pulse,
    input  held_long
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output tap_pulse,
    output long_pulse,
    output held_long
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: sync, debounce, then tap / long-hold classify.
// Ports: clk, rst (async high), bus.slave {btn_in -> level, tap, long, held}.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYC    = 20,
  parameter int unsigned LONG_CYC        = 1500,
  parameter int unsigned CNT_W           = 11,
  parameter bit          BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  btn_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  logic             pressed_raw;
  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic [CNT_W-1:0] deb_cnt;
  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             tap_q;
  logic             long_q;
  logic             held_q;

  // Normalise polarity so everything downstream is 1 = pressed.
  assign pressed_raw = bus.btn_in ~^ BTN_ACTIVE_HIGH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pressed_raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synced input agrees with the accepted
  // level restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      lvl     <= ~lvl;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Release is tested before the hold limit so a release on the
  // limit cycle still counts as a tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      tap_q    <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      tap_q  <= 1'b0;
      long_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lvl) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (!lvl) begin
            tap_q <= 1'b1;
            state <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_q <= 1'b1;
            held_q <= 1'b1;
            state  <= LONG;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (!lvl) begin
            held_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.btn_level  = lvl;
  assign bus.tap_pulse  = tap_q;
  assign bus.long_pulse = long_q;
  assign bus.held_long  = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: active-high and active-low builds share
// one stimulus stream and are checked against a run-length model.
module tb_btn_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk = 1'b0;
  logic rst;
  logic raw;

  int errs   = 0;
  int checks = 0;

  btn_conditioner_if bh ();
  btn_conditioner_if bl ();

  assign bh.btn_in = raw;
  assign bl.btn_in = ~raw;

  btn_conditioner #(
    .DEBOUNCE_CYC    (DEB),
    .LONG_CYC        (LONG),
    .CNT_W           (11),
    .BTN_ACTIVE_HIGH (1'b1)
  ) dut_h (
    .clk (clk),
    .rst (rst),
    .bus (bh)
  );

  btn_conditioner #(
    .DEBOUNCE_CYC    (DEB),
    .LONG_CYC        (LONG),
    .CNT_W           (11),
    .BTN_ACTIVE_HIGH (1'b0)
  ) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bl)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0b want %0b at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model: raw history delay line, mismatch run length for the
  // debouncer, and run length of the pressed level for classify.
  bit m_q0, m_q1;
  bit m_lvl, m_tap, m_long, m_held, m_done;
  int m_mis, m_run;

  function automatic void m_reset();
    m_q0   = 1'b0;
    m_q1   = 1'b0;
    m_lvl  = 1'b0;
    m_tap  = 1'b0;
    m_long = 1'b0;
    m_held = 1'b0;
    m_done = 1'b0;
    m_mis  = 0;
    m_run  = 0;
  endfunction

  function automatic void m_step(bit r);
    bit old;
    bit s;
    old  = m_lvl;
    s    = m_q0;
    m_q0 = m_q1;
    m_q1 = r;
    if (s != m_lvl) begin
      m_mis++;
      if (m_mis == DEB) begin
        m_lvl = !m_lvl;
        m_mis = 0;
      end
    end else begin
      m_mis = 0;
    end
    m_tap  = 1'b0;
    m_long = 1'b0;
    if (old) begin
      m_run++;
      if (!m_done && m_run == LONG + 1) begin
        m_long = 1'b1;
        m_held = 1'b1;
        m_done = 1'b1;
      end
    end else begin
      if (m_run > 0 && !m_done) m_tap = 1'b1;
      m_run  = 0;
      m_done = 1'b0;
      m_held = 1'b0;
    end
  endfunction

  task automatic compare_all();
    chk("h_level", bh.btn_level, m_lvl);
    chk("h_tap", bh.tap_pulse, m_tap);
    chk("h_long", bh.long_pulse, m_long);
    chk("h_held", bh.held_long, m_held);
    chk("l_level", bl.btn_level, m_lvl);
    chk("l_tap", bl.tap_pulse, m_tap);
    chk("l_long", bl.long_pulse, m_long);
    chk("l_held", bl.held_long, m_held);
  endtask

  task automatic step(bit r);
    raw = r;
    @(posedge clk);
    if (rst) m_reset();
    else m_step(r);
    #1;
    compare_all();
  endtask

  // Assert reset between edges and check the outputs drop at once.
  task automatic pulse_reset(int hold_cyc);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    compare_all();
    repeat (hold_cyc) step(raw);
    rst = 1'b0;
  endtask

  int len_tbl[3] = '{15, 16, 17};

  initial begin
    rst = 1'b1;
    raw = 1'b0;
    m_reset();
    repeat (3) step(1'b0);
    rst = 1'b0;

    repeat (50) step(1'b0);

    repeat (8) step(1'b1);
    repeat (20) step(1'b0);

    step(1'b1);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    repeat (10) step(1'b1);
    repeat (3) step(1'b0);
    repeat (2) step(1'b1);
    repeat (20) step(1'b0);

    repeat (40) step(1'b1);
    repeat (20) step(1'b0);

    foreach (len_tbl[i]) begin
      repeat (len_tbl[i]) step(1'b1);
      repeat (25) step(1'b0);
    end

    repeat (30) step(1'b1);
    pulse_reset(3);
    repeat (12) step(1'b1);
    repeat (20) step(1'b0);

    repeat (10) step(1'b1);
    pulse_reset(2);
    repeat (30) step(1'b1);
    repeat (20) step(1'b0);

    for (int seg = 0; seg < 150; seg++) begin
      bit lv;
      int len;
      lv  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 5) == 0) ?
            int'($urandom_range(30, 45)) :
            int'($urandom_range(1, 24));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) step(!lv);
        else step(lv);
      end
      if ($urandom_range(0, 40) == 0) pulse_reset(2);
    end
    repeat (30) step(1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
